lcd_page_writer: RTL and testbench

Sequencer that sits directly downstream of the text LUT in the LCD module. On a start request it walks the LUT for one page, word by word, and replays each 9-bit word (RS + 8-bit byte) onto a write-only HD44780-style parallel bus. It drives the setup, enable-pulse and execution-wait timing for each word. It stops at a terminator word or at the end of the page.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_wait_timer.sv | 32 +++
 rtl/lcd_page_writer.sv | 174 +++++++++++++++++
 tb/tb_lcd_page_writer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD page writer.
// Holds the sequencer state enum, the LUT terminator word, the HD44780
// clear/home command bytes, the RS bit position and a max helper used to
// size the shared wait timer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SETUP   = 3'd3,
    ST_PULSE   = 3'd4,
    ST_WAIT    = 3'd5,
    ST_DONE    = 3'd6,
    ST_REFRESH = 3'd7
  } lcd_state_e;

  localparam logic [8:0]  LCD_TERMINATOR = 9'h000;
  localparam logic [7:0]  LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0]  LCD_CMD_HOME   = 8'h02;
  localparam int unsigned LCD_RS_BIT     = 8;

  function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - reload the counter with load_val this edge
//   load_val   - value loaded (state duration minus one)
//   zero_c     - counter is zero (combinational decode of the count)
module lcd_wait_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/lcd_page_writer.sv
// Replays one page of the text LUT onto an HD44780-style write-only bus,
// generating setup, enable pulse and execution-wait timing per word.
// Stops at a 9'h000 terminator word or after MAX_WORDS words.
// Optional build macro: LCD_AUTO_REFRESH_EN - rewrite the same page after
// REFRESH_CYC idle cycles without a new start pulse.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, page_sel     - write request and page to write (sampled in IDLE)
//   busy, done          - write in progress / one-cycle completion pulse
//   lut_addr, lut_page  - LUT address outputs
//   lut_data            - LUT read data (1-cycle registered latency)
//   lcd_rs, lcd_rw, lcd_e, lcd_db - LCD parallel bus
module lcd_page_writer
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 9,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned PAGE_ADDR_WIDTH = 5,
  parameter int unsigned MAX_WORDS       = 64,
  parameter int unsigned SETUP_CYC       = 2,
  parameter int unsigned E_PULSE_CYC     = 25,
  parameter int unsigned CMD_WAIT_CYC    = 2000,
  parameter int unsigned CLR_WAIT_CYC    = 80000,
  parameter int unsigned REFRESH_CYC     = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [PAGE_ADDR_WIDTH-1:0] page_sel,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      lut_addr,
  output logic [PAGE_ADDR_WIDTH-1:0] lut_page,
  input  logic [DATA_WIDTH-1:0]      lut_data,
  output logic                       lcd_rs,
  output logic                       lcd_rw,
  output logic                       lcd_e,
  output logic [7:0]                 lcd_db
);

  localparam int unsigned TMR_MAX = lcd_max(lcd_max(SETUP_CYC, E_PULSE_CYC),
                                            lcd_max(lcd_max(CMD_WAIT_CYC, CLR_WAIT_CYC),
                                                    REFRESH_CYC));
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  lcd_state_e                 state, state_nxt;
  logic                       busy_nxt, done_nxt, e_nxt, rs_nxt;
  logic [7:0]                 db_nxt;
  logic [ADDR_WIDTH-1:0]      addr_nxt;
  logic [PAGE_ADDR_WIDTH-1:0] page_nxt;
  logic                       tmr_load, tmr_zero, is_clr_c;
  logic [TMR_W-1:0]           tmr_val;

  lcd_wait_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // Clear and home need the long execution wait.
  assign is_clr_c = !lcd_rs && ((lcd_db == LCD_CMD_CLEAR) || (lcd_db == LCD_CMD_HOME));
  assign lcd_rw   = 1'b0;

  // State and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lut_addr <= '0;
      lut_page <= '0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_db   <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      lut_addr <= addr_nxt;
      lut_page <= page_nxt;
      lcd_rs   <= rs_nxt;
      lcd_e    <= e_nxt;
      lcd_db   <= db_nxt;
    end
  end

  // Next-state, next-output and timer reload logic.
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    addr_nxt  = lut_addr;
    page_nxt  = lut_page;
    rs_nxt    = lcd_rs;
    db_nxt    = lcd_db;
    e_nxt     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          page_nxt  = page_sel;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: begin
        if (lut_data == DATA_WIDTH'(LCD_TERMINATOR)) begin
          state_nxt = ST_DONE;
        end else begin
          rs_nxt    = lut_data[LCD_RS_BIT];
          db_nxt    = lut_data[7:0];
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: if (tmr_zero) state_nxt = ST_PULSE;
      ST_PULSE: if (tmr_zero) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tmr_zero) begin
          // Last word of the page ends the write before the address can wrap.
          if (lut_addr == ADDR_WIDTH'(MAX_WORDS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            addr_nxt  = lut_addr + ADDR_WIDTH'(1);
            state_nxt = ST_FETCH;
          end
        end
      end
`ifdef LCD_AUTO_REFRESH_EN
      ST_DONE: state_nxt = ST_REFRESH;
      ST_REFRESH: begin
        // A new start overrides the pending refresh of the old page.
        if (start) begin
          page_nxt  = page_sel;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_FETCH;
        end else if (tmr_zero) begin
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
`else
      ST_DONE: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_DONE) begin
      done_nxt = 1'b1;
      busy_nxt = 1'b0;
    end
    e_nxt = (state_nxt == ST_PULSE);

    // Timer reloads on every state entry with the new state's duration minus one.
    if (state_nxt != state) begin
      tmr_load = 1'b1;
      case (state_nxt)
        ST_SETUP:   tmr_val = TMR_W'(SETUP_CYC - 1);
        ST_PULSE:   tmr_val = TMR_W'(E_PULSE_CYC - 1);
        ST_WAIT:    tmr_val = is_clr_c ? TMR_W'(CLR_WAIT_CYC - 1) : TMR_W'(CMD_WAIT_CYC - 1);
        ST_REFRESH: tmr_val = TMR_W'(REFRESH_CYC - 1);
        default:    tmr_val = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_page_writer.sv
// Self-checking bench for lcd_page_writer with short timing parameters and a
// behavioural 1-cycle-latency LUT holding a few test pages.
module tb_lcd_page_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] page_sel = '0;
  logic       busy, done, lcd_rs, lcd_rw, lcd_e;
  logic [5:0] lut_addr;
  logic [4:0] lut_page;
  logic [8:0] lut_data = '0;
  logic [7:0] lcd_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_page_writer #(
    .DATA_WIDTH(9), .ADDR_WIDTH(6), .PAGE_ADDR_WIDTH(5), .MAX_WORDS(8),
    .SETUP_CYC(1), .E_PULSE_CYC(3), .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20),
    .REFRESH_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .page_sel(page_sel),
    .busy(busy), .done(done), .lut_addr(lut_addr), .lut_page(lut_page),
    .lut_data(lut_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db(lcd_db)
  );

  // Behavioural LUT contents.
  function automatic logic [8:0] lut_word(input logic [4:0] p, input logic [5:0] a);
    logic [8:0] w;
    w = 9'h000;
    case (p)
      5'd0: if (a == 6'd0) w = 9'h101; else if (a == 6'd1) w = 9'h142;
      5'd1: if (a == 6'd0) w = 9'h001; else if (a == 6'd1) w = 9'h148;
      5'd2: if (a < 6'd8) w = 9'h130 + 9'(a); else w = 9'h1FF;
      5'd5: if (a == 6'd0) w = 9'h155;
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  always @(posedge clk) lut_data <= lut_word(lut_page, lut_addr);

  // Bus monitor: records E pulses, done pulses and address/page behaviour.
  logic       mon_clr = 1'b1;
  logic [4:0] exp_page = '0;
  logic       prev_e = 1'b0, prev_busy = 1'b0;
  int         n_pulse, n_done, max_addr, busy_bad, done_cyc;
  bit         page_bad;
  int         rise_cyc [16];
  int         fall_cyc [16];
  logic [8:0] word     [16];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_pulse = 0; n_done = 0; max_addr = 0; busy_bad = 0; page_bad = 0;
      prev_e = lcd_e; prev_busy = busy;
    end else begin
      if (lcd_e && !prev_e && n_pulse < 16) begin
        rise_cyc[n_pulse] = cyc;
        word[n_pulse] = {lcd_rs, lcd_db};
      end
      if (!lcd_e && prev_e && n_pulse < 16) begin
        fall_cyc[n_pulse] = cyc;
        n_pulse++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (busy || !prev_busy) busy_bad++;
      end
      if (busy && int'(lut_addr) > max_addr) max_addr = int'(lut_addr);
      if (busy && lut_page != exp_page) page_bad = 1'b1;
      prev_e = lcd_e;
      prev_busy = busy;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); @(negedge clk);
    mon_clr = 1'b0;
  endtask

  typedef struct {
    logic [4:0] page;
    int         restart;
    int         n_pulses;
    logic [8:0] first;
    logic [8:0] last;
    int         gap;
    int         max_addr;
  } vec_t;

  vec_t vecs [4];

  // Write one page, optionally re-pulsing start (page 5) mid-write, then check.
  task automatic run_vec(input vec_t v);
    bit done_seen;
    int widths_bad;
    int li;
    exp_page = v.page;
    clear_mon();
    page_sel = v.page; start = 1'b1;
    done_seen = 1'b0;
    for (int i = 1; i <= 600 && !done_seen; i++) begin
      @(negedge clk);
      if (i == v.restart) begin page_sel = 5'd5; start = 1'b1; end
      else start = 1'b0;
      if (done) done_seen = 1'b1;
    end
    start = 1'b0;
    check($sformatf("p%0d_done_seen", v.page), int'(done_seen), 1);
    repeat (3) @(negedge clk);
    check($sformatf("p%0d_pulses", v.page), n_pulse, v.n_pulses);
    li = (n_pulse > 0) ? n_pulse - 1 : 0;
    check($sformatf("p%0d_first_word", v.page), int'(word[0]), int'(v.first));
    check($sformatf("p%0d_last_word", v.page), int'(word[li]), int'(v.last));
    widths_bad = 0;
    for (int k = 0; k < n_pulse; k++)
      if (fall_cyc[k] - rise_cyc[k] != 3) widths_bad++;
    check($sformatf("p%0d_e_width_bad", v.page), widths_bad, 0);
    if (v.gap >= 0)
      check($sformatf("p%0d_gap01", v.page), rise_cyc[1] - fall_cyc[0], v.gap);
    check($sformatf("p%0d_done_count", v.page), n_done, 1);
    check($sformatf("p%0d_busy_with_done", v.page), busy_bad, 0);
    check($sformatf("p%0d_max_addr", v.page), max_addr, v.max_addr);
    check($sformatf("p%0d_page_changed", v.page), int'(page_bad), 0);
    check($sformatf("p%0d_busy_after", v.page), int'(busy), 0);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{5'd0,  0, 2, 9'h101, 9'h142,  8, 2};
    vecs[1] = '{5'd1,  0, 2, 9'h001, 9'h148, 23, 2};
    vecs[2] = '{5'd2, 20, 8, 9'h130, 9'h137,  8, 7};
    vecs[3] = '{5'd5,  0, 1, 9'h155, 9'h155, -1, 1};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(lut_addr), 0);
    check("rst_page", int'(lut_page), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_e", int'(lcd_e), 0);
    check("rst_db", int'(lcd_db), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      run_vec(vecs[i]);
    end

    // Reset during the enable pulse, then a clean rewrite.
    do_reset();
    page_sel = 5'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (lcd_e) seen = 1'b1;
    end
    check("rstpulse_e_seen", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstpulse_e", int'(lcd_e), 0);
    check("rstpulse_busy", int'(busy), 0);
    check("rstpulse_addr", int'(lut_addr), 0);
    check("rstpulse_page", int'(lut_page), 0);
    rst = 1'b0;
    run_vec(vecs[1]);

`ifdef LCD_AUTO_REFRESH_EN
    // Automatic rewrite of the same page after the refresh gap.
    begin
      int d;
      int busy_hi;
      do_reset();
      exp_page = 5'd0;
      page_sel = 5'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("refresh_first_done", int'(seen), 1);
      d = cyc;
      clear_mon();
      busy_hi = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy) busy_hi++;
      end
      check("refresh_busy_low", busy_hi, 0);
      for (int i = 0; i < 200 && n_pulse < 2; i++) @(negedge clk);
      check("refresh_pulses", n_pulse, 2);
      check("refresh_word0", int'(word[0]), 9'h101);
      check("refresh_word1", int'(word[1]), 9'h142);
      check("refresh_first_rise", rise_cyc[0] - d, 54);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
